// File: rtl/board_move_if.sv
// Command, render-read and move-event bundle between the key pulse
// generators / renderer / chess clock (master) and board_move_ctrl (slave).
interface board_move_if #(
   parameter int CW      = 3,
   parameter int PIECE_W = 4
);
   logic               enable;
   logic               cmd_valid;
   logic [2:0]         cmd;
   logic [CW-1:0]      rd_row;
   logic [CW-1:0]      rd_col;
   logic [PIECE_W-1:0] rd_piece;
   logic               busy;
   logic [CW-1:0]      cursor_row;
   logic [CW-1:0]      cursor_col;
   logic               sel_valid;
   logic [CW-1:0]      sel_row;
   logic [CW-1:0]      sel_col;
   logic               turn;
   logic               move_done;
   logic [CW-1:0]      move_from_row;
   logic [CW-1:0]      move_from_col;
   logic [CW-1:0]      move_to_row;
   logic [CW-1:0]      move_to_col;
   logic [PIECE_W-1:0] captured;
   logic               err;

   modport master (
      output enable, cmd_valid, cmd, rd_row, rd_col,
      input  rd_piece, busy, cursor_row, cursor_col, sel_valid, sel_row, sel_col,
             turn, move_done, move_from_row, move_from_col, move_to_row,
             move_to_col, captured, err
   );

   modport slave (
      input  enable, cmd_valid, cmd, rd_row, rd_col,
      output rd_piece, busy, cursor_row, cursor_col, sel_valid, sel_row, sel_col,
             turn, move_done, move_from_row, move_from_col, move_to_row,
             move_to_col, captured, err
   );
endinterface

// File: rtl/board_move_ctrl.sv
// Chess game-state engine: register-file board loaded by an INIT sequencer,
// cursor/select/commit move FSM, registered render read port, move events.
module board_move_ctrl #(
   parameter int BOARD_DIM   = 8,
   parameter int PIECE_W     = 4,
   parameter int EMPTY_CODE  = 15,
   parameter int CURSOR_WRAP = 0
) (
   input logic         clk,
   input logic         reset,
   board_move_if.slave bus
);
   localparam int CW  = (BOARD_DIM > 2) ? $clog2(BOARD_DIM) : 1;
   localparam int NSQ = BOARD_DIM * BOARD_DIM;
   localparam int IW  = $clog2(NSQ);
   localparam logic [CW-1:0]      LAST  = CW'(BOARD_DIM - 1);
   localparam logic [PIECE_W-1:0] EMPTY = PIECE_W'(EMPTY_CODE);

   localparam logic [2:0] CMD_UP     = 3'd0;
   localparam logic [2:0] CMD_DOWN   = 3'd1;
   localparam logic [2:0] CMD_LEFT   = 3'd2;
   localparam logic [2:0] CMD_RIGHT  = 3'd3;
   localparam logic [2:0] CMD_SELECT = 3'd4;
   localparam logic [2:0] CMD_CANCEL = 3'd5;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_HELD, S_COMMIT} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      init_row_q, init_row_d, init_col_q, init_col_d;
   logic [CW-1:0]      cursor_row_q, cursor_row_d, cursor_col_q, cursor_col_d;
   logic [CW-1:0]      sel_row_q, sel_row_d, sel_col_q, sel_col_d;
   logic               turn_q, turn_d;
   logic               err_q, err_d;
   logic               move_done_q;
   logic [CW-1:0]      from_row_q, from_col_q, to_row_q, to_col_q;
   logic [PIECE_W-1:0] captured_q;
   logic [PIECE_W-1:0] rd_piece_q;
   logic [PIECE_W-1:0] board_q [NSQ];

   logic               busy, accept;
   logic [IW-1:0]      cur_idx, sel_idx, rd_idx;
   logic [PIECE_W-1:0] cur_piece, sel_piece;

   function automatic logic [IW-1:0] sq_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
      return IW'(int'(r) * BOARD_DIM + int'(c));
   endfunction

   // Starting position; back rank repeats every 8 columns on wide boards.
   function automatic logic [PIECE_W-1:0] init_piece(input logic [CW-1:0] r, input logic [CW-1:0] c);
      int b;
      case (int'(c) % 8)
         0, 7:    b = 0;
         1, 6:    b = 1;
         2, 5:    b = 2;
         3:       b = 3;
         default: b = 4;
      endcase
      if (r == '0)                     return PIECE_W'(b);
      if (r == CW'(1))                 return PIECE_W'(5);
      if (r == CW'(BOARD_DIM - 2))     return PIECE_W'(11);
      if (r == LAST)                   return PIECE_W'(b + 6);
      return EMPTY;
   endfunction

   function automatic logic owned(input logic [PIECE_W-1:0] code, input logic player);
      if (!player) return int'(code) <= 5;
      return (int'(code) >= 6) && (int'(code) <= 11);
   endfunction

   function automatic logic [CW-1:0] step_dn(input logic [CW-1:0] v);
      if (v == '0) return (CURSOR_WRAP != 0) ? LAST : '0;
      return v - 1'b1;
   endfunction

   function automatic logic [CW-1:0] step_up(input logic [CW-1:0] v);
      if (v == LAST) return (CURSOR_WRAP != 0) ? '0 : LAST;
      return v + 1'b1;
   endfunction

   assign busy      = (state_q == S_INIT) || (state_q == S_COMMIT);
   assign accept    = bus.cmd_valid && bus.enable && !busy;
   assign cur_idx   = sq_idx(cursor_row_q, cursor_col_q);
   assign sel_idx   = sq_idx(sel_row_q, sel_col_q);
   assign rd_idx    = sq_idx(bus.rd_row, bus.rd_col);
   assign cur_piece = board_q[cur_idx];
   assign sel_piece = board_q[sel_idx];

   // Next-state logic: INIT scan, command decode in IDLE/HELD, one-cycle COMMIT.
   always_comb begin
      state_d      = state_q;
      init_row_d   = init_row_q;
      init_col_d   = init_col_q;
      cursor_row_d = cursor_row_q;
      cursor_col_d = cursor_col_q;
      sel_row_d    = sel_row_q;
      sel_col_d    = sel_col_q;
      turn_d       = turn_q;
      err_d        = 1'b0;
      unique case (state_q)
         S_INIT: begin
            if (init_col_q == LAST) begin
               init_col_d = '0;
               if (init_row_q == LAST) begin
                  init_row_d = '0;
                  state_d    = S_IDLE;
               end else begin
                  init_row_d = init_row_q + 1'b1;
               end
            end else begin
               init_col_d = init_col_q + 1'b1;
            end
         end
         S_IDLE, S_HELD: begin
            if (accept) begin
               case (bus.cmd)
                  CMD_UP:    cursor_row_d = step_dn(cursor_row_q);
                  CMD_DOWN:  cursor_row_d = step_up(cursor_row_q);
                  CMD_LEFT:  cursor_col_d = step_dn(cursor_col_q);
                  CMD_RIGHT: cursor_col_d = step_up(cursor_col_q);
                  CMD_SELECT: begin
                     if (state_q == S_IDLE) begin
                        if (owned(cur_piece, turn_q)) begin
                           state_d   = S_HELD;
                           sel_row_d = cursor_row_q;
                           sel_col_d = cursor_col_q;
                        end else begin
                           err_d = 1'b1;
                        end
                     end else if (cur_idx == sel_idx) begin
                        state_d = S_IDLE;
                     end else if (owned(cur_piece, turn_q)) begin
                        err_d = 1'b1;
                     end else begin
                        state_d = S_COMMIT;
                     end
                  end
                  CMD_CANCEL: state_d = S_IDLE;
                  default: ;
               endcase
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
            turn_d  = ~turn_q;
         end
         default: state_d = S_INIT;
      endcase
   end

   // Control state register; reset restarts the INIT scan from (0,0).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_INIT;
         init_row_q   <= '0;
         init_col_q   <= '0;
         cursor_row_q <= '0;
         cursor_col_q <= '0;
         sel_row_q    <= '0;
         sel_col_q    <= '0;
         turn_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_row_q   <= init_row_d;
         init_col_q   <= init_col_d;
         cursor_row_q <= cursor_row_d;
         cursor_col_q <= cursor_col_d;
         sel_row_q    <= sel_row_d;
         sel_col_q    <= sel_col_d;
         turn_q       <= turn_d;
         err_q        <= err_d;
      end
   end

   // Move event record, latched in the COMMIT cycle and held until the next move.
   always_ff @(posedge clk) begin
      if (reset) begin
         move_done_q <= 1'b0;
         from_row_q  <= '0;
         from_col_q  <= '0;
         to_row_q    <= '0;
         to_col_q    <= '0;
         captured_q  <= EMPTY;
      end else begin
         move_done_q <= (state_q == S_COMMIT);
         if (state_q == S_COMMIT) begin
            from_row_q <= sel_row_q;
            from_col_q <= sel_col_q;
            to_row_q   <= cursor_row_q;
            to_col_q   <= cursor_col_q;
            captured_q <= cur_piece;
         end
      end
   end

   // Board storage: INIT loads one square per cycle, COMMIT moves the held piece.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state_q == S_INIT) begin
            board_q[sq_idx(init_row_q, init_col_q)] <= init_piece(init_row_q, init_col_q);
         end else if (state_q == S_COMMIT) begin
            board_q[cur_idx] <= sel_piece;
            board_q[sel_idx] <= EMPTY;
         end
      end
   end

   // Registered render read; forwards the COMMIT writes so the new board shows immediately.
   always_ff @(posedge clk) begin
      if (reset || state_q == S_INIT)                     rd_piece_q <= EMPTY;
      else if (state_q == S_COMMIT && rd_idx == cur_idx)  rd_piece_q <= sel_piece;
      else if (state_q == S_COMMIT && rd_idx == sel_idx)  rd_piece_q <= EMPTY;
      else                                                rd_piece_q <= board_q[rd_idx];
   end

   assign bus.rd_piece      = rd_piece_q;
   assign bus.busy          = busy;
   assign bus.cursor_row    = cursor_row_q;
   assign bus.cursor_col    = cursor_col_q;
   assign bus.sel_valid     = (state_q == S_HELD) || (state_q == S_COMMIT);
   assign bus.sel_row       = sel_row_q;
   assign bus.sel_col       = sel_col_q;
   assign bus.turn          = turn_q;
   assign bus.move_done     = move_done_q;
   assign bus.move_from_row = from_row_q;
   assign bus.move_from_col = from_col_q;
   assign bus.move_to_row   = to_row_q;
   assign bus.move_to_col   = to_col_q;
   assign bus.captured      = captured_q;
   assign bus.err           = err_q;
endmodule

// File: doc/board_move_ctrl.md
# board_move_ctrl

Parametrised game-state engine for the chess design. It replaces the fixed, power-up-initialised 8x8 board array with a register-file board of configurable dimension. The board is loaded by a sequencer after reset and updated by a cursor/select/commit move FSM driven by debounced key commands. It sits between the keypress pulse generators and the screen generator/board renderer in the 50 MHz domain, and exposes a registered read port for rendering plus move-event outputs for the chess clock.

## Interface
- BOARD_DIM, 8, squares per side (4..16); CW = max(1, $clog2(BOARD_DIM)) coordinate width
- PIECE_W, 4, piece code width; codes 0-5 belong to player 0, 6-11 to player 1, anything else is unowned
- EMPTY_CODE, 15, code written to vacant squares
- CURSOR_WRAP, 0, 0 = cursor saturates at board edges, 1 = cursor wraps modulo BOARD_DIM

- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- enable  in  1  game running (screen FSM in play state); commands are ignored when low
- cmd_valid  in  1  one-cycle command strobe
- cmd  in  3  command: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 SELECT, 5 CANCEL, 6-7 no-op
- rd_row, rd_col  in  CW each  render read address
- rd_piece  out  PIECE_W  piece at (rd_row, rd_col), registered
- busy  out  1  high during INIT or COMMIT
- cursor_row, cursor_col  out  CW each  cursor position
- sel_valid  out  1  a piece is held
- sel_row, sel_col  out  CW each  held piece square
- turn  out  1  player to move (0 or 1)
- move_done  out  1  one-cycle pulse on a completed move
- move_from_row, move_from_col, move_to_row, move_to_col  out  CW each  coordinates of the last move, held until the next move
- captured  out  PIECE_W  destination content before the last move (EMPTY_CODE if no capture)
- err  out  1  one-cycle pulse on an illegal SELECT

## Operation
- States: INIT, IDLE, HELD, COMMIT.
- INIT: the sequencer writes one square per cycle in row-major order, BOARD_DIM*BOARD_DIM cycles, then enters IDLE.
  - Row 0, col c gets BACK[c mod 8], where BACK = {0,1,2,3,4,2,1,0}.
  - Row 1 gets 5.
  - Row BOARD_DIM-2 gets 11.
  - Row BOARD_DIM-1 gets BACK[c mod 8]+6.
  - All other squares get EMPTY_CODE.
- Commands are accepted only when cmd_valid=1, enable=1 and busy=0. Otherwise they are dropped silently, with no err.
- UP/DOWN change the row by -1/+1; LEFT/RIGHT change the col by -1/+1. Edge behaviour follows CURSOR_WRAP. Moves are allowed in IDLE and HELD.
- SELECT in IDLE:
  - If the cursor square is owned by turn: go to HELD and latch sel = cursor.
  - Otherwise (opponent piece or unowned): pulse err and stay in IDLE.
- SELECT in HELD:
  - Cursor == sel: deselect and go to IDLE, no err.
  - Cursor square owned by turn: pulse err and stay in HELD.
  - Otherwise: go to COMMIT.
- CANCEL in HELD: go to IDLE. CANCEL in IDLE is a no-op.
- COMMIT (exactly 1 cycle):
  - Write dest = piece at sel and src = EMPTY_CODE.
  - Latch captured, from and to; pulse move_done.
  - Toggle turn, clear sel_valid, go to IDLE.
- No move legality check beyond ownership; piece rules are out of scope.
- Reset in any state (including mid-INIT or COMMIT) restarts INIT from square (0,0). No partial move survives.

## Timing
- Reset values:
  - State INIT, busy=1.
  - cursor=(0,0), sel=(0,0), sel_valid=0, turn=0.
  - move_done=0, err=0, move_from/to=0, captured=EMPTY_CODE, rd_piece=EMPTY_CODE.
- busy drops on the cycle after the last INIT write, which is BOARD_DIM*BOARD_DIM+1 cycles after reset deasserts.
- A command accepted at edge t updates cursor/sel/state at t+1. err pulses at t+1 for exactly one cycle.
- A committing SELECT at edge t:
  - COMMIT state and busy=1 during t+1.
  - Board write, move_done, turn toggle and the move coordinates all become visible at t+2.
  - A cmd_valid during t+1 is dropped.
- Read latency is 1 cycle: the address at edge t gives rd_piece at t+1. A read of the square written in COMMIT returns the new value from t+2. rd_piece = EMPTY_CODE while in INIT.
- enable falling while in HELD keeps the selection. Commands resume when enable returns.

## Test plan
- Reset then wait 65 cycles (BOARD_DIM=8) → busy low. Reads give (0,3)=3, (1,4)=5, (7,4)=10, (6,0)=11, (4,4)=15.
- Cursor to (1,4), SELECT, DOWN, DOWN to (3,4), SELECT → move_done one cycle at t+2; from=(1,4), to=(3,4), captured=15; (3,4)=5, (1,4)=15; turn=1.
- With turn=0, SELECT on (6,0) → err one pulse, sel_valid=0. Then SELECT on an own piece, move onto another own piece, SELECT → err, still HELD.
- CURSOR_WRAP=0: LEFT at col 0 → col stays 0. CURSOR_WRAP=1, BOARD_DIM=8: LEFT at col 0 → col 7, DOWN at row 7 → row 0.
- Capture: a player-0 piece moves onto (6,2)=11 → captured=11, destination=moving code. A cmd_valid during the COMMIT cycle is ignored.
- Assert reset mid-INIT (cycle 20) and during COMMIT → INIT restarts, turn=0, and the full initial board is reloaded.
